// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/hazard controller with order tagging and retire tracking.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int NUM_STAGES  = 5,
  parameter int HAZ_STAGE   = 1,
  parameter int FLUSH_STAGE = 2,
  parameter int ORDER_W     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imem_stall,
  input  logic                  dmem_stall,
  input  logic                  load_hazard,
  input  logic                  flush,
  input  logic                  fetch_valid,
  output logic [NUM_STAGES-1:0] stage_we,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic [ORDER_W-1:0]    fetch_order,
  output logic                  retire_valid,
  output logic [ORDER_W-1:0]    retire_order,
  output logic [31:0]           perf_stall_cyc,
  output logic [31:0]           perf_flush_cnt
);

  if (!(HAZ_STAGE >= 0 && HAZ_STAGE < FLUSH_STAGE && FLUSH_STAGE <= NUM_STAGES - 2)) begin : g_param_check
    $error("pipe_ctrl: illegal HAZ_STAGE/FLUSH_STAGE/NUM_STAGES combination");
  end

  logic                  g;
  logic                  accept;
  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] valid_nxt;
  logic                  ret_done_q;
  logic [ORDER_W-1:0]    fetch_cnt_q;
  logic [ORDER_W-1:0]    retire_cnt_q;

  assign g      = imem_stall | dmem_stall;
  assign accept = fetch_valid & ~g & ~flush & ~load_hazard;

  // Flush wins over the hazard, so the hazard only freezes the front when no flush is present.
  always_comb begin
    stage_we = '0;
    if (!g) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        stage_we[i] = (i <= HAZ_STAGE) ? ~(load_hazard & ~flush) : 1'b1;
      end
    end
  end

  always_comb begin
    valid_nxt = valid_q;
    if (!g) begin
      valid_nxt = {valid_q[NUM_STAGES-2:0], fetch_valid};
      if (flush) begin
        for (int i = 0; i < NUM_STAGES; i++) begin
          if (i <= FLUSH_STAGE) valid_nxt[i] = 1'b0;
        end
      end else if (load_hazard) begin
        for (int i = 0; i < NUM_STAGES; i++) begin
          if (i <= HAZ_STAGE) valid_nxt[i] = valid_q[i];
          else if (i == HAZ_STAGE + 1) valid_nxt[i] = 1'b0;
        end
      end
    end
  end

  assign retire_valid = valid_q[NUM_STAGES-1] & ~ret_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      ret_done_q   <= 1'b0;
      fetch_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      valid_q <= valid_nxt;
      // A writeback held by a stall has already retired; remember it until the pipe moves.
      if (g) begin
        if (retire_valid) ret_done_q <= 1'b1;
      end else begin
        ret_done_q <= 1'b0;
      end
      if (accept)       fetch_cnt_q  <= fetch_cnt_q + 1'b1;
      if (retire_valid) retire_cnt_q <= retire_cnt_q + 1'b1;
    end
  end

  assign stage_valid  = valid_q;
  assign fetch_order  = fetch_cnt_q;
  assign retire_order = retire_cnt_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cyc_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((g | load_hazard) && stall_cyc_q != 32'hFFFF_FFFF) stall_cyc_q <= stall_cyc_q + 32'd1;
      if (!g && flush && flush_cnt_q != 32'hFFFF_FFFF)       flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cyc = stall_cyc_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cyc = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: advance, stall, hazard, flush, order wrap and reset.
// A second instance with ORDER_W=4 shares the stimulus to exercise counter wrap.
module tb_pipe_ctrl;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst, imem_stall, dmem_stall, load_hazard, flush, fetch_valid;
  logic [N-1:0] stage_we, stage_valid;
  logic [63:0]  fetch_order, retire_order;
  logic         retire_valid;
  logic [31:0]  perf_stall_cyc, perf_flush_cnt;

  logic [N-1:0] stage_we4, stage_valid4;
  logic [3:0]   fetch_order4, retire_order4;
  logic         retire_valid4;
  logic [31:0]  perf_stall_cyc4, perf_flush_cnt4;

  int n_cmp = 0;
  int n_bad = 0;
  logic [N-1:0] ev;

  always #5 clk = ~clk;

  pipe_ctrl u_dut (
    .clk(clk), .rst(rst), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .load_hazard(load_hazard), .flush(flush), .fetch_valid(fetch_valid),
    .stage_we(stage_we), .stage_valid(stage_valid), .fetch_order(fetch_order),
    .retire_valid(retire_valid), .retire_order(retire_order),
    .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
  );

  pipe_ctrl #(.ORDER_W(4)) u_w4 (
    .clk(clk), .rst(rst), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .load_hazard(load_hazard), .flush(flush), .fetch_valid(fetch_valid),
    .stage_we(stage_we4), .stage_valid(stage_valid4), .fetch_order(fetch_order4),
    .retire_valid(retire_valid4), .retire_order(retire_order4),
    .perf_stall_cyc(perf_stall_cyc4), .perf_flush_cnt(perf_flush_cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic r, input logic is, input logic ds,
                       input logic lh, input logic fl, input logic fv);
    rst = r; imem_stall = is; dmem_stall = ds; load_hazard = lh; flush = fl; fetch_valid = fv;
    #1;
  endtask

  task automatic check_all(input string tag, input logic [N-1:0] we, input logic [N-1:0] v,
                           input logic rv, input logic [63:0] ro, input logic [63:0] fo);
    chk({tag, "_we"}, 64'(stage_we), 64'(we));
    chk({tag, "_valid"}, 64'(stage_valid), 64'(v));
    chk({tag, "_rv"}, 64'(retire_valid), 64'(rv));
    chk({tag, "_ro"}, retire_order, ro);
    chk({tag, "_fo"}, fetch_order, fo);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    tick();
    tick();
    check_all("reset", 5'h1f, 5'h00, 1'b0, 64'd0, 64'd0);
    chk("reset_perf_stall", 64'(perf_stall_cyc), 64'd0);
    chk("reset_perf_flush", 64'(perf_flush_cnt), 64'd0);

    // Streaming fetch, no stalls: first retire five cycles after the first accept.
    for (int c = 0; c <= 10; c++) begin
      drive(0, 0, 0, 0, 0, 1);
      ev = '0;
      for (int i = 0; i < N; i++) if (c > i) ev[i] = 1'b1;
      chk("adv_valid", 64'(stage_valid), 64'(ev));
      chk("adv_fetch_order", fetch_order, 64'(c));
      chk("adv_retire_valid", 64'(retire_valid), (c >= 5) ? 64'd1 : 64'd0);
      if (c >= 5) chk("adv_retire_order", retire_order, 64'(c - 5));
      chk("adv_we", 64'(stage_we), 64'h1f);
      tick();
    end

    // Data-memory stall for three cycles with writeback occupied.
    drive(0, 0, 1, 0, 0, 1);
    check_all("stall1", 5'h00, 5'h1f, 1'b1, 64'd6, 64'd11);
    tick();
    check_all("stall2", 5'h00, 5'h1f, 1'b0, 64'd7, 64'd11);
    tick();
    check_all("stall3", 5'h00, 5'h1f, 1'b0, 64'd7, 64'd11);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    check_all("post_stall", 5'h1f, 5'h1f, 1'b0, 64'd7, 64'd11);
    tick();

    // Single-cycle load hazard with a full pipe.
    drive(0, 0, 0, 1, 0, 1);
    check_all("hazard", 5'b11100, 5'h1f, 1'b1, 64'd7, 64'd12);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    check_all("haz_next", 5'h1f, 5'b11011, 1'b1, 64'd8, 64'd12);
    tick();
    check_all("bubble_mv", 5'h1f, 5'b10111, 1'b1, 64'd9, 64'd13);
    tick();
    check_all("bubble_gap", 5'h1f, 5'b01111, 1'b0, 64'd10, 64'd14);
    tick();

    // Flush together with a hazard: flush wins.
    drive(0, 0, 0, 1, 1, 1);
    check_all("flush_haz", 5'h1f, 5'h1f, 1'b1, 64'd10, 64'd15);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    check_all("post_flush", 5'h1f, 5'b11000, 1'b1, 64'd11, 64'd15);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall", 64'(perf_stall_cyc), 64'd5);
    chk("perf_flush", 64'(perf_flush_cnt), 64'd1);
`else
    chk("perf_stall_off", 64'(perf_stall_cyc), 64'd0);
    chk("perf_flush_off", 64'(perf_flush_cnt), 64'd0);
`endif
    tick();
    check_all("flush_adv", 5'h1f, 5'b10001, 1'b1, 64'd12, 64'd16);

    // Reset, then 17 accepts on the 4-bit order instance to cross the wrap.
    drive(1, 0, 0, 0, 0, 1);
    tick();
    check_all("rst2", 5'h1f, 5'h00, 1'b0, 64'd0, 64'd0);
    chk("rst2_fo4", 64'(fetch_order4), 64'd0);
    for (int k = 0; k <= 16; k++) begin
      drive(0, 0, 0, 0, 0, 1);
      chk("wrap_fo4", 64'(fetch_order4), 64'(k % 16));
      tick();
    end
    drive(0, 0, 1, 0, 0, 1);
    chk("wrap_last_fo4", 64'(fetch_order4), 64'd1);
    chk("wrap_stall_we", 64'(stage_we), 64'd0);
    tick();

    // Reset while the stall is still asserted.
    drive(1, 0, 1, 0, 0, 1);
    chk("pre_rst_fo4", 64'(fetch_order4), 64'd1);
    tick();
    check_all("rst_stall", 5'h00, 5'h00, 1'b0, 64'd0, 64'd0);
    chk("rst_stall_fo4", 64'(fetch_order4), 64'd0);
    chk("rst_stall_ro4", 64'(retire_order4), 64'd0);
    chk("rst_stall_perf_stall", 64'(perf_stall_cyc), 64'd0);
    chk("rst_stall_perf_flush", 64'(perf_flush_cnt), 64'd0);
    drive(0, 0, 0, 0, 0, 0);
    check_all("after_rst", 5'h1f, 5'h00, 1'b0, 64'd0, 64'd0);
    tick();
    check_all("idle", 5'h1f, 5'h00, 1'b0, 64'd0, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
